// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V core: opcodes, datapath selects, controller states.
package riscv_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned STATE_W = 3;

    // Base opcodes handled by the controller
    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

    // pc_src encodings
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;

    // alu_src_a encodings
    localparam logic [1:0] ALU_A_OLD_PC = 2'd0;
    localparam logic [1:0] ALU_A_RS1    = 2'd1;
    localparam logic [1:0] ALU_A_ZERO   = 2'd2;

    // alu_src_b encodings
    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    // wb_sel encodings
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    // Controller states
    localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd4;
    localparam logic [STATE_W-1:0] ST_WB     = 3'd5;
    localparam logic [STATE_W-1:0] ST_HALT   = 3'd6;

    // True for opcodes that proceed from DECODE to EXEC
    function automatic logic is_exec_op(input logic [OP_W-1:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mc_controller.sv
// Multi-cycle sequencing controller: FETCH/DECODE/EXEC/MEM/WB with retired-instruction counter.
module mc_controller
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            alu_force_add,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic            halted,
    output logic            illegal,
    output logic [XLEN-1:0] instret
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic               illegal_q, illegal_d;
    logic [XLEN-1:0]    instret_q, instret_d;

    // State, latched opcode, sticky illegal flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            op_q      <= '0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and Moore output decode; FETCH handshake strobes also follow mem_ready
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        instret_d     = instret_q;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        alu_src_a     = ALU_A_OLD_PC;
        alu_src_b     = ALU_B_RS2;
        alu_force_add = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        halted        = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (is_exec_op(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_HALT;
                    if (opcode != OP_SYSTEM) illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_src_a = ALU_A_RS1;
                        alu_src_b = ALU_B_RS2;
                        state_d   = ST_WB;
                    end
                    OP_I: begin
                        alu_src_a = ALU_A_RS1;
                        alu_src_b = ALU_B_IMM;
                        state_d   = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a     = ALU_A_RS1;
                        alu_src_b     = ALU_B_IMM;
                        alu_force_add = 1'b1;
                        state_d       = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = ALU_A_RS1;
                        alu_src_b = ALU_B_RS2;
                        pc_src    = PC_SRC_TARGET;
                        pc_write  = branch_taken;
                        state_d   = ST_FETCH;
                    end
                    OP_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_TARGET;
                        state_d  = ST_WB;
                    end
                    OP_LUI: begin
                        alu_src_a     = ALU_A_ZERO;
                        alu_src_b     = ALU_B_IMM;
                        alu_force_add = 1'b1;
                        state_d       = ST_WB;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_STORE);
                if (mem_ready) state_d = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LOAD)     wb_sel = WB_MEM;
                else if (op_q == OP_JAL) wb_sel = WB_PC;
                else                     wb_sel = WB_ALU;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_RESET;
        endcase

        // Retire on the edge that returns to FETCH from EXEC, MEM or WB
        if ((state_d == ST_FETCH) &&
            ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)))
            instret_d = instret_q + XLEN'(1);
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
